// File: rtl/cmp_lab_pkg.sv
// Purpose: shared types and helpers for the comparator lab blocks (sweep state, defaults, vector count).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmp_lab_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

    localparam int DEFAULT_N      = 2;
    localparam int DEFAULT_SETTLE = 2;

    // Number of (A,B) pairs for an n-bit operand width.
    function automatic int unsigned num_vectors(input int unsigned n);
        return 32'd1 << (2 * n);
    endfunction

    // Bits needed by a down-counter that is loaded with settle-1.
    function automatic int unsigned timer_width(input int unsigned settle);
        return (settle < 2) ? 32'd1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Purpose: loadable down-counter with a zero flag; times how long a lab vector is held.
// Latency: load/decrement take effect on the next rising edge; zero_o is decoded from the register.
// Backpressure: none; the counter saturates at zero when decremented there.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset (counter clears to 0)
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one when not already zero
//   zero_o      counter currently holds zero
module settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cmp_sweep_checker.sv
// Purpose: drives every (A,B) pair into an N-bit unsigned greater-than comparator and checks dut_gt against A>B.
// Latency: each vector is held SETTLE+1 cycles; done rises 2^(2N)*(SETTLE+1) edges after the start edge.
// Backpressure: none; start is ignored while busy, and rst aborts a sweep at any time.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   start                      one-cycle pulse that begins a sweep from IDLE or DONE
//   dut_a, dut_b               registered operands to the comparator (A-major order)
//   dut_gt                     comparator result under test
//   busy                       sweep in progress (DRIVE or SAMPLE)
//   done, pass                 sweep finished; pass when no vector mismatched
//   err_count                  mismatching vectors in the current/last sweep
//   fail_seen                  sticky flag for the first mismatch of the sweep
//   first_fail_a/first_fail_b  operands of the first mismatching vector
module cmp_sweep_checker
    import cmp_lab_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [N-1:0]   dut_a,
    output logic [N-1:0]   dut_b,
    input  logic           dut_gt,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*N:0]   err_count,
    output logic           fail_seen,
    output logic [N-1:0]   first_fail_a,
    output logic [N-1:0]   first_fail_b
);

    localparam int IDX_W = 2 * N;
    localparam int ERR_W = 2 * N + 1;
    localparam int TMR_W = int'(timer_width(SETTLE));

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_vectors(N) - 1);
    // DRIVE exits when the timer reads zero, so loading SETTLE-1 gives SETTLE cycles in DRIVE.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE - 1);

    sweep_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fail_seen_q, fail_seen_d;
    logic [N-1:0]     ffa_q, ffa_d;
    logic [N-1:0]     ffb_q, ffb_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;
    logic mismatch;

    settle_timer #(
        .W (TMR_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (TMR_LOAD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Operands come straight from the vector index register, so they are glitch-free.
    assign dut_a = idx_q[IDX_W-1:N];
    assign dut_b = idx_q[N-1:0];

    assign mismatch = dut_gt ^ (dut_a > dut_b);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        fail_seen_d = fail_seen_q;
        ffa_d       = ffa_q;
        ffb_d       = ffb_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_DRIVE;
                    idx_d       = '0;
                    err_d       = '0;
                    fail_seen_d = 1'b0;
                    ffa_d       = '0;
                    ffb_d       = '0;
                    tmr_load    = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + ERR_W'(1);
                    if (!fail_seen_q) begin
                        fail_seen_d = 1'b1;
                        ffa_d       = dut_a;
                        ffb_d       = dut_b;
                    end
                end
                // The last vector ends the sweep with idx left on it, so dut_a/dut_b hold it in DONE.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    state_d  = ST_DRIVE;
                    tmr_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            err_q       <= '0;
            fail_seen_q <= 1'b0;
            ffa_q       <= '0;
            ffb_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            fail_seen_q <= fail_seen_d;
            ffa_q       <= ffa_d;
            ffb_q       <= ffb_d;
        end
    end

    assign busy         = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done         = (state_q == ST_DONE);
    assign pass         = done && (err_q == '0);
    assign err_count    = err_q;
    assign fail_seen    = fail_seen_q;
    assign first_fail_a = ffa_q;
    assign first_fail_b = ffb_q;

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Purpose: scoreboard bench for cmp_sweep_checker with a behavioural comparator that can inject faults.
// Latency: expected done latency comes from the vector count and hold time.
// Backpressure: n/a.
module tb_cmp_sweep_checker;

    typedef struct {
        int err;
        int pass;
        int fseen;
        int ffa;
        int ffb;
        int lat;
        int nvec;
        int start_cyc;
    } exp_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    // Instance 0: N=2, SETTLE=2
    logic [1:0] a0, b0, ffa0, ffb0;
    logic [4:0] err0;
    logic       busy0, done0, pass0, fs0, gt0;
    bit   [15:0] mask0 = '0;

    // Instance 1: N=3, SETTLE=1
    logic [2:0] a1, b1, ffa1, ffb1;
    logic [6:0] err1;
    logic       busy1, done1, pass1, fs1, gt1;
    bit   [63:0] mask1 = '0;

    // Comparator under test: correct A>B, inverted for every pair whose mask bit is set.
    assign gt0 = (a0 > b0) ^ mask0[{a0, b0}];
    assign gt1 = (a1 > b1) ^ mask1[{a1, b1}];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cmp_sweep_checker #(.N(2), .SETTLE(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .dut_a(a0), .dut_b(b0), .dut_gt(gt0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_seen(fs0),
        .first_fail_a(ffa0), .first_fail_b(ffb0)
    );

    cmp_sweep_checker #(.N(3), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_gt(gt1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_seen(fs1),
        .first_fail_a(ffa1), .first_fail_b(ffb1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the square of operands A-major, ask the faulty comparator, compare to A>B.
    function automatic exp_t model(input int n, input int settle, input bit [63:0] mask);
        exp_t e;
        int   side;
        bit   want, got;
        e    = '{default: 0};
        side = 1 << n;
        for (int a = 0; a < side; a++) begin
            for (int b = 0; b < side; b++) begin
                want = (a > b);
                got  = want ^ mask[a * side + b];
                if (got != want) begin
                    if (e.fseen == 0) begin
                        e.fseen = 1;
                        e.ffa   = a;
                        e.ffb   = b;
                    end
                    e.err++;
                end
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        e.nvec = side * side;
        e.lat  = e.nvec * (settle + 1);
        return e;
    endfunction

    // Vector-order monitors: each new vector while busy must be the next A-major index.
    int          vexp0 = 0, vexp1 = 0;
    bit          bprev0 = 1'b0, bprev1 = 1'b0;
    logic [3:0]  vprev0 = '0;
    logic [5:0]  vprev1 = '0;

    always @(negedge clk) begin
        if (busy0 && (!bprev0 || ({a0, b0} != vprev0))) begin
            if (!bprev0) vexp0 = 0;
            check("order0", int'({a0, b0}), vexp0);
            vexp0++;
        end
        bprev0 = busy0;
        vprev0 = {a0, b0};
    end

    always @(negedge clk) begin
        if (busy1 && (!bprev1 || ({a1, b1} != vprev1))) begin
            if (!bprev1) vexp1 = 0;
            check("order1", int'({a1, b1}), vexp1);
            vexp1++;
        end
        bprev1 = busy1;
        vprev1 = {a1, b1};
    end

    // Done monitors: pop the scoreboard when done rises and compare the sweep results.
    bit dprev0 = 1'b0, dprev1 = 1'b0;

    always @(negedge clk) begin : mon0
        exp_t e;
        if (done0 && !dprev0) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done0_unexpected: done rose with no sweep pending");
            end else begin
                e = q0.pop_front();
                check("lat0",   cyc - e.start_cyc, e.lat);
                check("err0",   int'(err0), e.err);
                check("pass0",  int'(pass0), e.pass);
                check("fseen0", int'(fs0), e.fseen);
                check("ffa0",   int'(ffa0), e.ffa);
                check("ffb0",   int'(ffb0), e.ffb);
                check("nvec0",  vexp0, e.nvec);
                check("last0",  int'({a0, b0}), e.nvec - 1);
                check("busy_in_done0", int'(busy0), 0);
            end
        end
        dprev0 = done0;
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1 && !dprev1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done1_unexpected: done rose with no sweep pending");
            end else begin
                e = q1.pop_front();
                check("lat1",   cyc - e.start_cyc, e.lat);
                check("err1",   int'(err1), e.err);
                check("pass1",  int'(pass1), e.pass);
                check("fseen1", int'(fs1), e.fseen);
                check("ffa1",   int'(ffa1), e.ffa);
                check("ffb1",   int'(ffb1), e.ffb);
                check("nvec1",  vexp1, e.nvec);
                check("last1",  int'({a1, b1}), e.nvec - 1);
                check("busy_in_done1", int'(busy1), 0);
            end
        end
        dprev1 = done1;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy0"}, int'(busy0), 0);
        check({tag, "_done0"}, int'(done0), 0);
        check({tag, "_pass0"}, int'(pass0), 0);
        check({tag, "_err0"},  int'(err0), 0);
        check({tag, "_fs0"},   int'(fs0), 0);
        check({tag, "_ff0"},   int'({ffa0, ffb0}), 0);
        check({tag, "_ab0"},   int'({a0, b0}), 0);
        check({tag, "_all1"},  int'({busy1, done1, pass1, err1, fs1, ffa1, ffb1, a1, b1}), 0);
    endtask

    // One sweep on instance `which`; the result is checked by that instance's done monitor.
    task automatic run(input int which, input bit [63:0] mask, input bit repulse);
        exp_t e;
        bit   seen;
        if (which == 0) begin
            mask0 = mask[15:0];
            e     = model(2, 2, mask);
        end else begin
            mask1 = mask;
            e     = model(3, 1, mask);
        end
        @(negedge clk);
        e.start_cyc = cyc + 1;
        if (which == 0) begin
            q0.push_back(e);
            start0 = 1'b1;
        end else begin
            q1.push_back(e);
            start1 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        check($sformatf("busy_after_start%0d", which), int'(which != 0 ? busy1 : busy0), 1);
        check($sformatf("done_after_start%0d", which), int'(which != 0 ? done1 : done0), 0);
        check($sformatf("err_after_start%0d", which),  int'(which != 0 ? err1 : 7'(err0)), 0);
        check($sformatf("fs_after_start%0d", which),   int'(which != 0 ? fs1 : fs0), 0);
        if (repulse) begin
            @(negedge clk);
            if (which == 0) start0 = 1'b1; else start1 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; (k < e.lat + 20) && !seen; k++) begin
            @(negedge clk);
            seen = (which != 0) ? done1 : done0;
        end
        @(negedge clk);
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout%0d: done got 0, expected 1 within %0d cycles", which, e.lat + 20);
            if (which == 0 && q0.size() > 0) void'(q0.pop_back());
            if (which != 0 && q1.size() > 0) void'(q1.pop_back());
        end
    endtask

    initial begin
        #1_000_000;
        $display("watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [63:0] m;
        exp_t      e;
        bit        seen;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Correct comparator, then stuck-at-0, then inverted output
        run(0, 64'h0, 1'b0);
        m = '0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                m[a * 4 + b] = (a > b);
        run(0, m, 1'b0);
        run(0, 64'hFFFF, 1'b0);

        // start re-pulsed mid-sweep must be ignored
        run(0, 64'h0, 1'b1);

        // Random fault patterns
        for (int i = 0; i < 5; i++) begin
            m = 64'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) m = '0;
            run(0, m, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-sweep at vector 01/01
        mask0 = 16'h0004;
        e = model(2, 2, 64'h0004);
        @(negedge clk);
        e.start_cyc = cyc + 1;
        q0.push_back(e);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; (k < 100) && !seen; k++) begin
            @(negedge clk);
            seen = (a0 == 2'd1) && (b0 == 2'd1);
        end
        check("reach_vec5", int'(seen), 1);
        check("err_before_rst", int'(err0), 1);
        check("fs_before_rst", int'(fs0), 1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        if (q0.size() > 0) void'(q0.pop_back());
        repeat (4) @(negedge clk);
        check("idle_after_rst_busy", int'(busy0), 0);
        check("idle_after_rst_done", int'(done0), 0);
        run(0, 64'h0, 1'b0);

        // Wider instance: correct comparator then random faults
        run(1, 64'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            m = {32'($urandom & $urandom & $urandom), 32'($urandom & $urandom)};
            run(1, m, 1'($urandom_range(0, 1)));
        end

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
